// File: rtl/lenet_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lenet_pkg
// Description : Shared types and constants for the LeNet host sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package lenet_pkg;

    localparam int unsigned C_FC2_BASE  = 743;
    localparam int unsigned C_NUM_CLASS = 10;
    localparam int unsigned C_ACT_AW    = 16;
    localparam int unsigned C_ACT_DW    = 32;
    localparam int unsigned C_IDX_W     = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_READ  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } host_state_e;

endpackage
`default_nettype wire

// File: rtl/lenet_host_ctrl_argmax_acc.sv
`default_nettype none
// ============================================================================
// Module      : argmax_acc
// Description : Running signed maximum and its index over a stream of words.
// Revision    : 1.0 - initial release
// ============================================================================
module argmax_acc
    import lenet_pkg::*;
#(
    parameter int unsigned DW = C_ACT_DW,
    parameter int unsigned IW = C_IDX_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          valid,
    input  logic [DW-1:0] data,
    input  logic [IW-1:0] idx,
    output logic [DW-1:0] upd_val,
    output logic [IW-1:0] upd_idx
);

    logic [DW-1:0] max_q, max_d;
    logic [IW-1:0] idx_q, idx_d;

    // Strictly-greater replacement keeps the lowest index on ties.
    always_comb begin
        max_d = max_q;
        idx_d = idx_q;
        if (clear) begin
            max_d = '0;
            idx_d = '0;
        end else if (valid && ((idx == '0) || ($signed(data) > $signed(max_q)))) begin
            max_d = data;
            idx_d = idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
            idx_q <= '0;
        end else begin
            max_q <= max_d;
            idx_q <= idx_d;
        end
    end

    // Exposes the value including this cycle's word so the final compare
    // can be captured on the same edge that enters DONE.
    assign upd_val = max_d;
    assign upd_idx = idx_d;

endmodule
`default_nettype wire

// File: rtl/lenet_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lenet_host_ctrl
// Description : Host sequencer: start LeNet, watchdog, read logits, argmax.
// Revision    : 1.0 - initial release
// ============================================================================
module lenet_host_ctrl
    import lenet_pkg::*;
#(
    parameter int unsigned FC2_BASE       = C_FC2_BASE,
    parameter int unsigned NUM_CLASS      = C_NUM_CLASS,
    parameter int unsigned TIMEOUT_CYCLES = 26000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                host_start,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [C_IDX_W-1:0]  pred_class,
    output logic [C_ACT_DW-1:0] pred_score,
    output logic                compute_start,
    input  logic                compute_finish,
    output logic                act_port_req,
    output logic [3:0]          sram_act_wea1,
    output logic [C_ACT_AW-1:0] sram_act_addr1,
    output logic [C_ACT_DW-1:0] sram_act_wdata1,
    input  logic [C_ACT_DW-1:0] sram_act_rdata1
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]    WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [C_IDX_W-1:0] RD_LAST = C_IDX_W'(NUM_CLASS - 1);

    host_state_e state_q, state_d;

    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic [C_IDX_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic                cmp_valid_q, cmp_valid_d;
    logic [C_IDX_W-1:0]  cmp_idx_q, cmp_idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;
    logic                start_q, start_d;
    logic                req_q, req_d;
    logic [C_IDX_W-1:0]  pred_class_q, pred_class_d;
    logic [C_ACT_DW-1:0] pred_score_q, pred_score_d;
    logic [C_ACT_AW-1:0] addr_q, addr_d;

    logic                start_accept;
    logic [C_ACT_DW-1:0] acc_val;
    logic [C_IDX_W-1:0]  acc_idx;

    assign start_accept = (state_q == S_IDLE) && host_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The first WAIT cycle (watchdog still 0) ignores a stale finish level;
    // finish takes priority over the watchdog limit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (host_start) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (compute_finish && (wdog_q != '0)) begin
                    state_d = S_READ;
                end else if (wdog_q == WD_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_READ:  if (rd_cnt_q == RD_LAST) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes from a flop.
    always_comb begin
        wdog_d       = wdog_q;
        timeout_d    = timeout_q;
        pred_class_d = pred_class_q;
        pred_score_d = pred_score_q;

        if (start_accept) begin
            wdog_d = '0;
        end else if (state_q == S_WAIT) begin
            wdog_d = wdog_q + 1'b1;
        end

        rd_cnt_d    = (state_q == S_READ) ? rd_cnt_q + 1'b1 : '0;
        cmp_valid_d = (state_q == S_READ);
        cmp_idx_d   = rd_cnt_q;

        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        start_d = (state_d == S_START);
        req_d   = (state_d == S_READ) || (state_d == S_DRAIN);
        addr_d  = (state_d == S_READ) ? (C_ACT_AW'(FC2_BASE) + C_ACT_AW'(rd_cnt_d)) : '0;

        if (start_accept) begin
            timeout_d = 1'b0;
        end else if (state_d == S_ERR) begin
            timeout_d = 1'b1;
        end

        if (state_d == S_DONE) begin
            pred_class_d = acc_idx;
            pred_score_d = acc_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q       <= '0;
            rd_cnt_q     <= '0;
            cmp_valid_q  <= 1'b0;
            cmp_idx_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            start_q      <= 1'b0;
            req_q        <= 1'b0;
            pred_class_q <= '0;
            pred_score_q <= '0;
            addr_q       <= '0;
        end else begin
            wdog_q       <= wdog_d;
            rd_cnt_q     <= rd_cnt_d;
            cmp_valid_q  <= cmp_valid_d;
            cmp_idx_q    <= cmp_idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            start_q      <= start_d;
            req_q        <= req_d;
            pred_class_q <= pred_class_d;
            pred_score_q <= pred_score_d;
            addr_q       <= addr_d;
        end
    end

    argmax_acc #(
        .DW (C_ACT_DW),
        .IW (C_IDX_W)
    ) u_argmax (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start_accept),
        .valid   (cmp_valid_q),
        .data    (sram_act_rdata1),
        .idx     (cmp_idx_q),
        .upd_val (acc_val),
        .upd_idx (acc_idx)
    );

    assign busy            = busy_q;
    assign done            = done_q;
    assign timeout         = timeout_q;
    assign pred_class      = pred_class_q;
    assign pred_score      = pred_score_q;
    assign compute_start   = start_q;
    assign act_port_req    = req_q;
    assign sram_act_addr1  = addr_q;
    assign sram_act_wea1   = '0;
    assign sram_act_wdata1 = '0;

endmodule
`default_nettype wire

// File: doc/lenet_host_ctrl.md
# lenet_host_ctrl

Host-side sequencer for the LeNet accelerator, acting as the initiator of the `compute_start`/`compute_finish` handshake. On a host request it pulses `compute_start` and waits for `compute_finish` under a cycle watchdog. It then reads the FC2 logits back through activation-SRAM port 1 and reports the argmax class and its score. It sits between the system host and `lenet`, and it borrows act-SRAM port 1 only after the accelerator has finished.

## Interface
- `FC2_BASE`, default 743: act-SRAM word address of logit 0.
- `NUM_CLASS`, default 10: number of logits, each one signed 32-bit word.
- `TIMEOUT_CYCLES`, default 26000: watchdog limit for the WAIT state.
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `host_start`, in, 1: request to run one inference; sampled only in IDLE.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when the result is valid.
- `timeout`, out, 1: sticky error flag; cleared by the next accepted `host_start`.
- `pred_class`, out, 4: argmax index; held until the next accepted start.
- `pred_score`, out, 32: signed logit at `pred_class`.
- `compute_start`, out, 1: one-cycle start pulse to `lenet`.
- `compute_finish`, in, 1: completion level from `lenet`.
- `act_port_req`, out, 1: high while this block owns act-SRAM port 1; it drives the external port mux.
- `sram_act_wea1`, out, 4: byte write enables; constant 0 because this block only reads.
- `sram_act_addr1`, out, 16: read address.
- `sram_act_wdata1`, out, 32: constant 0.
- `sram_act_rdata1`, in, 32: read data, returned one cycle after the address is presented.

## Operation
- **States:** IDLE, START, WAIT, READ, DRAIN, DONE, ERR.
- **IDLE to START:** taken when `host_start` is high.
  - Clears `timeout`, the watchdog counter and the running maximum.
  - `host_start` is ignored in every other state.
- **START:** `compute_start`=1 for exactly this cycle, then go to WAIT.
- **WAIT:** the watchdog counter increments every cycle.
  - `compute_finish` is ignored in the first WAIT cycle, so a stale level from a previous run is rejected.
  - After that, `compute_finish`=1 moves to READ.
  - Counter reaching `TIMEOUT_CYCLES`-1 without finish moves to ERR.
  - If finish and the limit occur in the same cycle, finish wins.
- **READ:** `act_port_req`=1; the address steps `FC2_BASE`..`FC2_BASE+NUM_CLASS-1`, one per cycle; after the last address go to DRAIN.
- **DRAIN:** one cycle to capture the final read word, then go to DONE.
- **Argmax:**
  - Each returned word is compared signed against the running maximum.
  - Index 0 is loaded unconditionally.
  - A later word replaces the maximum only when it is strictly greater, so ties resolve to the lowest index.
  - A 4-bit index register with 32-bit signed compare is sufficient.
- **DONE:** `done`=1 for one cycle, `pred_class`/`pred_score` are updated, then go to IDLE.
- **ERR:** `timeout`=1 (sticky), `pred_*` keep their previous values, `done` is not pulsed; go to IDLE in the following cycle.
- **Reset mid-operation:** abandons the run immediately and returns to IDLE; no `done` is produced.

## Timing
- **Reset values:** state IDLE; `busy`, `done`, `timeout`, `compute_start`, `act_port_req` all 0; `pred_class`=0; `pred_score`=0; `sram_act_addr1`=0; `sram_act_wea1`=0; `sram_act_wdata1`=0.
- **Registered outputs:** all outputs are registered, with no combinational path from input to output.
- **Start pulse:** `compute_start` rises on the clock edge after the `host_start` sample.
- **Read pipeline:**
  - Address k is presented in READ cycle k.
  - Its data is compared in cycle k+1.
  - The last compare happens in the DRAIN cycle.
- **Latency from finish to done:** from the cycle `compute_finish` is accepted to the `done` pulse is `NUM_CLASS`+2 cycles, i.e. 12 at defaults.
- **Port ownership:** `act_port_req` is high in READ and DRAIN only; at all other times port 1 outputs sit at 0.

## Structure
- **Shared package `lenet_pkg`:**
  - State encoding typedef.
  - Default constants for `FC2_BASE` (743) and `NUM_CLASS` (10).
  - Activation-SRAM address width (16) and data width (32).
- **Sub-module:** one natural sub-module, `argmax_acc`, holding the running max/index registers with `clear`, `valid`, `data`, and `idx` inputs. The FSM, watchdog and SRAM addressing stay in the top module.

## Test plan
- **Nominal run:** a `lenet` stub asserts finish 500 cycles after start; logits = {5,-3,7,2,7,0,1,-9,4,3}. Require `pred_class`=2, `pred_score`=7, `done` 12 cycles after finish, exactly one `compute_start` pulse.
- **All negative:** logits = {-100,…,-10 ascending} with the last one the largest. Require `pred_class`=9 and `pred_score`=0xFFFFFFF6 (signed compare, not unsigned).
- **Watchdog:** finish is never asserted. Require `timeout`=1 at cycle 26000 of WAIT, no `done`, return to IDLE; the next `host_start` clears `timeout`.
- **Stale finish:** `compute_finish` is held high from before start. Require that it is ignored in the first WAIT cycle, READ is entered in the second WAIT cycle, and the result is correct.
- **Reset in READ:** assert `rst_n`=0 at address 747. Require all outputs return to their reset values asynchronously, no `done`, and a clean full run afterwards.
- **Start while busy:** pulse `host_start` during WAIT and READ. Require no second `compute_start`, the result unchanged, and `busy` high continuously until DONE.
